// File: rtl/stall_ctrl.sv
// stall_ctrl: hazard/stall decision for the 5-stage pipeline.
// Decodes the D instruction, tracks dest/Tnew shadows for E and M, and
// raises stall when a D source is needed before its producer can supply it.
module stall_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      IR_D,
    output logic             stall,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             ID_EX_reset,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // Decoded view of the D instruction
    typedef struct packed {
        logic       rs_use;
        logic [1:0] rs_tuse;
        logic       rt_use;
        logic [1:0] rt_tuse;
        logic [4:0] dest;
        logic [1:0] tnew;
    } dec_t;

    logic [5:0] op, funct;
    logic [4:0] rs, rt, rd;
    logic       unused_shamt;
    dec_t       dec;

    assign op           = IR_D[31:26];
    assign rs           = IR_D[25:21];
    assign rt           = IR_D[20:16];
    assign rd           = IR_D[15:11];
    assign funct        = IR_D[5:0];
    assign unused_shamt = ^IR_D[10:6];

    logic [4:0]       a3_e_q, a3_e_d, a3_m_q, a3_m_d;
    logic [1:0]       tnew_e_q, tnew_e_d, tnew_m_q, tnew_m_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    // Source usage, Tuse and destination/Tnew for the D instruction
    always_comb begin
        dec = '0;
        unique case (op)
            OP_RTYPE: begin
                if (funct == FN_ADDU || funct == FN_SUBU) begin
                    dec.rs_use = 1'b1;
                    dec.rs_tuse = 2'd1;
                    dec.rt_use = 1'b1;
                    dec.rt_tuse = 2'd1;
                    dec.dest = rd;
                    dec.tnew = 2'd1;
                end else if (funct == FN_JR) begin
                    dec.rs_use = 1'b1;
                    dec.rs_tuse = 2'd0;
                end
            end
            OP_ORI: begin
                dec.rs_use = 1'b1;
                dec.rs_tuse = 2'd1;
                dec.dest = rt;
                dec.tnew = 2'd1;
            end
            OP_LUI: begin
                dec.dest = rt;
                dec.tnew = 2'd1;
            end
            OP_LW: begin
                dec.rs_use = 1'b1;
                dec.rs_tuse = 2'd1;
                dec.dest = rt;
                dec.tnew = 2'd2;
            end
            OP_SW: begin
                dec.rs_use = 1'b1;
                dec.rs_tuse = 2'd1;
                dec.rt_use = 1'b1;
                dec.rt_tuse = 2'd2;
            end
            OP_BEQ: begin
                dec.rs_use = 1'b1;
                dec.rs_tuse = 2'd0;
                dec.rt_use = 1'b1;
                dec.rt_tuse = 2'd0;
            end
            OP_JAL: begin
                dec.dest = 5'd31;
                dec.tnew = 2'd0;
            end
            default: dec = '0;
        endcase
    end

    // One source is blocked if its producer in E or M is still too far away
    function automatic logic src_hazard(input logic use_s, input logic [4:0] s,
                                        input logic [1:0] tuse,
                                        input logic [4:0] a3e, input logic [1:0] tne,
                                        input logic [4:0] a3m, input logic [1:0] tnm);
        return use_s && (s != 5'd0) &&
               ((s == a3e && tuse < tne) || (s == a3m && tuse < tnm));
    endfunction

    // Stall decision and derived enables
    always_comb begin
        stall = src_hazard(dec.rs_use, rs, dec.rs_tuse, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q) |
                src_hazard(dec.rt_use, rt, dec.rt_tuse, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q);
        pc_en       = ~stall;
        if_id_en    = ~stall;
        ID_EX_reset = stall;
    end

    // Next shadow state: bubble into E on stall, E ages into M every cycle
    always_comb begin
        a3_e_d        = stall ? 5'd0 : dec.dest;
        tnew_e_d      = stall ? 2'd0 : dec.tnew;
        a3_m_d        = a3_e_q;
        tnew_m_d      = (tnew_e_q == 2'd0) ? 2'd0 : tnew_e_q - 2'd1;
        stall_count_d = stall_count_q;
        if (stall && !(&stall_count_q))
            stall_count_d = stall_count_q + 1'b1;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            a3_e_q        <= '0;
            tnew_e_q      <= '0;
            a3_m_q        <= '0;
            tnew_m_q      <= '0;
            stall_count_q <= '0;
        end else begin
            a3_e_q        <= a3_e_d;
            tnew_e_q      <= tnew_e_d;
            a3_m_q        <= a3_m_d;
            tnew_m_q      <= tnew_m_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Bench for stall_ctrl: directed instruction stream, a record-based
// in-flight model compared every cycle, plus literal stall/count pins.
module tb_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR_D;
    logic        stall, pc_en, if_id_en, ID_EX_reset;
    logic [31:0] stall_count;

    int n_tests = 0;
    int n_fail  = 0;
    bit checking = 1'b0;

    stall_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .IR_D(IR_D), .stall(stall), .pc_en(pc_en),
        .if_id_en(if_id_en), .ID_EX_reset(ID_EX_reset), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    // An in-flight producer: its destination and the latency it had on entering E.
    typedef struct { int dest; int tnew_entry; } rec_t;
    rec_t in_e, in_m;
    int   m_count;

    typedef struct { int n; int src[2]; int tuse[2]; int dest; int tnew; } info_t;

    function automatic info_t info_of(input logic [31:0] ir);
        info_t r;
        int op, fn, rs, rt, rd;
        op = int'(ir[31:26]); fn = int'(ir[5:0]);
        rs = int'(ir[25:21]); rt = int'(ir[20:16]); rd = int'(ir[15:11]);
        r.n = 0; r.src[0] = 0; r.src[1] = 0; r.tuse[0] = 0; r.tuse[1] = 0;
        r.dest = 0; r.tnew = 0;
        if (op == 0 && (fn == 'h21 || fn == 'h23)) begin
            r.n = 2; r.src[0] = rs; r.src[1] = rt; r.tuse[0] = 1; r.tuse[1] = 1;
            r.dest = rd; r.tnew = 1;
        end else if (op == 0 && fn == 'h08) begin
            r.n = 1; r.src[0] = rs; r.tuse[0] = 0;
        end else if (op == 'h0D) begin
            r.n = 1; r.src[0] = rs; r.tuse[0] = 1; r.dest = rt; r.tnew = 1;
        end else if (op == 'h0F) begin
            r.dest = rt; r.tnew = 1;
        end else if (op == 'h23) begin
            r.n = 1; r.src[0] = rs; r.tuse[0] = 1; r.dest = rt; r.tnew = 2;
        end else if (op == 'h2B) begin
            r.n = 2; r.src[0] = rs; r.src[1] = rt; r.tuse[0] = 1; r.tuse[1] = 2;
        end else if (op == 'h04) begin
            r.n = 2; r.src[0] = rs; r.src[1] = rt; r.tuse[0] = 0; r.tuse[1] = 0;
        end else if (op == 'h03) begin
            r.dest = 31; r.tnew = 0;
        end
        return r;
    endfunction

    // Cycles until a record's result is usable, given how many stages it has aged past E.
    function automatic int remaining(input rec_t r, input int age);
        return (r.tnew_entry - age > 0) ? r.tnew_entry - age : 0;
    endfunction

    function automatic bit model_stall(input logic [31:0] ir);
        info_t d = info_of(ir);
        bit    s = 1'b0;
        for (int i = 0; i < d.n; i++) begin
            if (d.src[i] != 0) begin
                if (d.src[i] == in_e.dest && d.tuse[i] < remaining(in_e, 0)) s = 1'b1;
                if (d.src[i] == in_m.dest && d.tuse[i] < remaining(in_m, 1)) s = 1'b1;
            end
        end
        return s;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Compare every cycle, then advance the model to the post-edge state
    always @(negedge clk) begin
        if (checking) begin
            bit    es;
            info_t d;
            es = model_stall(IR_D);
            chk("stall", longint'(stall), longint'(es));
            chk("pc_en", longint'(pc_en), longint'(!es));
            chk("if_id_en", longint'(if_id_en), longint'(!es));
            chk("ID_EX_reset", longint'(ID_EX_reset), longint'(es));
            chk("stall_count", longint'(stall_count), longint'(m_count));
            if (reset) begin
                in_e = '{0, 0}; in_m = '{0, 0}; m_count = 0;
            end else begin
                // Records keep their entry latency; ageing into M is implied by the slot.
                in_m = in_e;
                d = info_of(IR_D);
                in_e = es ? '{0, 0} : '{d.dest, d.tnew};
                if (es) m_count++;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    typedef struct { bit rst; logic [31:0] ir; bit exp_stall; int exp_cnt; } vec_t;
    vec_t vecs[$];

    task automatic add(input bit rst, input logic [31:0] ir, input bit es, input int cnt);
        vec_t v;
        v.rst = rst; v.ir = ir; v.exp_stall = es; v.exp_cnt = cnt;
        vecs.push_back(v);
    endtask

    initial begin
        in_e = '{0, 0}; in_m = '{0, 0}; m_count = 0;
        reset = 1'b1; IR_D = 32'h0;

        add(1, 32'h0, 0, -1);
        add(0, 32'h0, 0, 0);  add(0, 32'h0, 0, 0);  add(0, 32'h0, 0, 0);
        add(0, 32'h00221821, 0, -1);             // addu $3,$1,$2
        add(0, 32'h10600001, 1, 0);              // beq $3,$0 : stalls
        add(0, 32'h10600001, 0, 1);              // proceeds
        add(0, 32'h0, 0, -1);
        add(0, 32'h8C040000, 0, -1);             // lw $4
        add(0, 32'h00842821, 1, -1);             // addu $5,$4,$4
        add(0, 32'h00842821, 0, 2);
        add(0, 32'h8C040000, 0, -1);             // lw $4
        add(0, 32'hAC040000, 0, -1);             // sw $4 : Tuse 2 not < 2
        add(0, 32'h8C040000, 0, -1);             // lw $4
        add(0, 32'h10800001, 1, 2);              // beq $4,$0 : 2 cycles
        add(0, 32'h10800001, 1, 3);
        add(0, 32'h10800001, 0, 4);
        add(0, 32'h0C000010, 0, -1);             // jal
        add(0, 32'h03E00008, 0, -1);             // jr $31
        add(0, 32'h00220021, 0, -1);             // addu $0,$1,$2
        add(0, 32'h10000001, 0, -1);             // beq $0,$0
        add(0, 32'h34060001, 0, -1);             // ori $6,$0,1
        add(0, 32'h00C00008, 1, -1);             // jr $6
        add(0, 32'h00C00008, 0, -1);
        add(0, 32'h3C070001, 0, -1);             // lui $7
        add(0, 32'hAC070000, 0, -1);             // sw $7 : Tuse 2
        add(0, 32'h8C040000, 0, 5);              // lw $4
        add(1, 32'h10800001, 1, 5);              // beq $4 stalls; reset this cycle
        add(0, 32'h10800001, 0, 0);              // state cleared
        add(0, 32'h10800001, 0, 0);

        @(posedge clk); #1;
        checking = 1'b1;
        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            IR_D  = vecs[i].ir;
            #3;
            chk($sformatf("vec%0d_stall", i), longint'(stall), longint'(vecs[i].exp_stall));
            if (vecs[i].exp_cnt >= 0)
                chk($sformatf("vec%0d_count", i), longint'(stall_count), longint'(vecs[i].exp_cnt));
            @(posedge clk); #1;
        end
        @(negedge clk);
        #1;
        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stall_ctrl.md
Name: stall_ctrl

Overview:
Hazard and stall controller for the 5-stage pipeline. It decodes the instruction in D (IR_D) and keeps its own shadow records of the destination register and the remaining result latency (Tnew) for the instructions in E and M. It produces the stall that freezes PC and IF/ID and drives the ID_EX_reset input of the D→E pipeline register, which inserts a bubble into E. Forwarding is handled elsewhere; this block only decides stalls.

Parameters:
CNT_W, 32, width of the saturating stall-cycle counter

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
IR_D  input  32  instruction currently in D (0 = nop)
stall  output  1  combinational; 1 = D instruction must wait this cycle
pc_en  output  1  ~stall; PC write enable
if_id_en  output  1  ~stall; IF/ID register write enable
ID_EX_reset  output  1  = stall; bubble into the D→E register at the next edge
stall_count  output  CNT_W  number of stalled cycles since reset; saturates at all-ones

Behaviour:
- Supported decode (op/funct):
  - addu 000000/100001 and subu 000000/100011: src rs, rt; Tuse 1/1; dest rd; Tnew 1.
  - ori 001101: src rs; Tuse 1; dest rt; Tnew 1.
  - lui 001111: no src; dest rt; Tnew 1.
  - lw 100011: src rs; Tuse 1; dest rt; Tnew 2.
  - sw 101011: src rs Tuse 1, rt Tuse 2; no dest.
  - beq 000100: src rs, rt; Tuse 0/0; no dest.
  - jr 000000/001000: src rs; Tuse 0; no dest.
  - jal 000011: dest 31; Tnew 0.
  - j 000010: no src or dest.
  - Anything else, including all-zero: no src or dest.
- Tnew values above apply on entry to E.
- State registers: a3_e[4:0], tnew_e[1:0], a3_m[4:0], tnew_m[1:0]. All are 0 after reset.
- Hazard on one source s with Tuse u:
  - The hazard exists when s≠0 and either (s==a3_e and u<tnew_e) or (s==a3_m and u<tnew_m).
  - stall is the OR over all sources of the D instruction.
  - stall is purely combinational from IR_D and the state registers, valid in the same cycle.
- Update at each posedge clk (reset not asserted):
  - If stall=1: a3_e←0, tnew_e←0 (bubble). Otherwise a3_e and tnew_e take the decoded dest and Tnew of IR_D.
  - a3_m←a3_e and tnew_m←max(tnew_e−1,0), regardless of stall.
  - If stall=1 and stall_count is not all-ones, stall_count increments by 1.
- Reset (synchronous): all state registers and stall_count go to 0. Reset overrides the stall update, including mid-stall.
  - During the reset cycle, stall is still computed from the current state.
  - After the reset edge, stall=0, pc_en=1, if_id_en=1, ID_EX_reset=0.
- Register 0 never causes a stall, even when a3_e or a3_m is 0.
- W stage is not tracked: Tnew in W is always 0, so W never stalls.
- Maximum stall length:
  - 2 cycles: lw followed by beq/jr on the loaded register.
  - 1 cycle: any other dependency that causes a stall.
- A continuous stall never deadlocks. Each stall inserts a bubble, so the blocking record moves to M with a lower Tnew.

Test Plan:
- Reset, then IR_D=0 for 3 cycles → stall=0 every cycle, stall_count=0, pc_en=1.
- 0x00221821 (addu $3,$1,$2) then 0x10600001 (beq $3,$0) in D → stall=1 for exactly 1 cycle, ID_EX_reset=1 that cycle; beq proceeds next cycle; stall_count=1.
- 0x8C040000 (lw $4) then 0x00842821 (addu $5,$4,$4) → 1-cycle stall. The same lw then 0xAC040000 (sw $4) → no stall (Tuse 2 is not below Tnew 2).
- 0x8C040000 then 0x10800001 (beq $4,$0) → stall for 2 consecutive cycles, then release; stall_count advances by 2.
- 0x0C000010 (jal) then 0x03E00008 (jr $31) → no stall. An ALU op writing $0 followed by a beq on $0 → no stall.
- Assert reset during the first cycle of a lw→beq 2-cycle stall → next cycle stall=0, all shadow state 0, stall_count=0.
